ulpi_phy_regs: RTL and testbench

ULPI_PHY_REGS -- requirements
Module: ulpi_phy_regs

---
 rtl/ulpi_phy_regs_if.sv | 37 +++
 rtl/ulpi_phy_regs.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_ulpi_phy_regs.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ulpi_phy_regs_if.sv
// ULPI bus between link and PHY, plus the RX CMD injection handshake.
// The link drives data_i/stp; the PHY owns dir/nxt/data_o/data_t.
interface ulpi_phy_regs_if;
    logic [7:0] ULPI_data_i;
    logic [7:0] ULPI_data_o;
    logic [7:0] ULPI_data_t;
    logic       ULPI_dir;
    logic       ULPI_nxt;
    logic       ULPI_stp;
    logic       rxcmd_valid;
    logic       rxcmd_ready;
    logic [7:0] rxcmd_data;

    modport master (
        output ULPI_data_i,
        output ULPI_stp,
        output rxcmd_valid,
        output rxcmd_data,
        input  ULPI_data_o,
        input  ULPI_data_t,
        input  ULPI_dir,
        input  ULPI_nxt,
        input  rxcmd_ready
    );

    modport slave (
        input  ULPI_data_i,
        input  ULPI_stp,
        input  rxcmd_valid,
        input  rxcmd_data,
        output ULPI_data_o,
        output ULPI_data_t,
        output ULPI_dir,
        output ULPI_nxt,
        output rxcmd_ready
    );
endinterface

// File: rtl/ulpi_phy_regs.sv
// PHY-side ULPI register block: TX CMD decode, register read/write/set/clear,
// transmit packet byte counting and RX CMD injection.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | bus idle, decoding TX CMDs and offering RX CMD slot
// WR_ADDR   | register write, first nxt cycle
// WR_DATA   | register write, second nxt cycle, data captured here
// WR_STP    | register write, waiting for stp to commit
// RD_ACK    | register read, nxt acknowledge
// RD_TA1    | register read, turnaround to PHY
// RD_DATA   | register read, PHY drives register value
// RD_TA2    | register read, turnaround back to link
// TX_PKT    | transmit packet, counting bytes until stp
// RX_TA1    | RX CMD, turnaround to PHY
// RX_DATA   | RX CMD, PHY drives latched RX CMD byte
// RX_TA2    | RX CMD, turnaround back to link
module ulpi_phy_regs #(
    parameter logic [15:0] VENDOR_ID  = 16'h0424,
    parameter logic [15:0] PRODUCT_ID = 16'h0009
) (
    input  logic           aclk,
    input  logic           areset,
    ulpi_phy_regs_if.slave bus,
    output logic [7:0]     func_ctrl,
    output logic [7:0]     iface_ctrl,
    output logic [7:0]     otg_ctrl,
    output logic [7:0]     scratch,
    output logic           phy_reset_pulse,
    output logic           pkt_done,
    output logic [11:0]    pkt_len
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_WR_STP,
        S_RD_ACK,
        S_RD_TA1,
        S_RD_DATA,
        S_RD_TA2,
        S_TX_PKT,
        S_RX_TA1,
        S_RX_DATA,
        S_RX_TA2
    } state_t;

    localparam logic [1:0] OP_WR  = 2'd0;
    localparam logic [1:0] OP_SET = 2'd1;
    localparam logic [1:0] OP_CLR = 2'd2;

    localparam logic [7:0] FUNC_RST  = 8'h41;
    localparam logic [7:0] IFACE_RST = 8'h00;
    localparam logic [7:0] OTG_RST   = 8'h06;
    localparam logic [7:0] SCR_RST   = 8'h00;

    state_t      state;
    state_t      state_nxt;

    logic [5:0]  addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rxd_q;
    logic [11:0] len_q;

    logic [7:0]  func_q;
    logic [7:0]  iface_q;
    logic [7:0]  otg_q;
    logic [7:0]  scratch_q;
    logic        pulse_q;

    logic        tx_cmd;
    logic        rx_accept;
    logic        wr_commit;
    logic [3:0]  grp;
    logic [1:0]  op;
    logic [7:0]  rd_val;
    logic [7:0]  func_new;

    function automatic logic [7:0] reg_update(input logic [1:0] opc,
                                              input logic [7:0] cur,
                                              input logic [7:0] d);
        case (opc)
            OP_SET:  return cur | d;
            OP_CLR:  return cur & ~d;
            default: return d;
        endcase
    endfunction

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt           = state;
        bus.ULPI_dir        = 1'b0;
        bus.ULPI_nxt        = 1'b0;
        bus.ULPI_data_t     = 8'hFF;
        bus.ULPI_data_o     = 8'h00;
        bus.rxcmd_ready     = 1'b0;
        pkt_done            = 1'b0;
        tx_cmd              = 1'b0;
        rx_accept           = 1'b0;
        wr_commit           = 1'b0;

        case (state)
            S_IDLE: begin
                tx_cmd          = !bus.ULPI_dir && (bus.ULPI_data_i[7:6] != 2'b00);
                bus.rxcmd_ready = !areset && !tx_cmd && (bus.ULPI_data_i == 8'h00);
                rx_accept       = bus.rxcmd_ready && bus.rxcmd_valid;
                if (tx_cmd) begin
                    case (bus.ULPI_data_i[7:6])
                        2'b10:   state_nxt = S_WR_ADDR;
                        2'b11:   state_nxt = S_RD_ACK;
                        default: state_nxt = S_TX_PKT;
                    endcase
                end else if (rx_accept) begin
                    state_nxt = S_RX_TA1;
                end
            end
            S_WR_ADDR: begin
                bus.ULPI_nxt = 1'b1;
                state_nxt    = bus.ULPI_stp ? S_IDLE : S_WR_DATA;
            end
            S_WR_DATA: begin
                bus.ULPI_nxt = 1'b1;
                state_nxt    = bus.ULPI_stp ? S_IDLE : S_WR_STP;
            end
            S_WR_STP: begin
                wr_commit = bus.ULPI_stp;
                state_nxt = S_IDLE;
            end
            S_RD_ACK: begin
                bus.ULPI_nxt = 1'b1;
                state_nxt    = S_RD_TA1;
            end
            S_RD_TA1: begin
                bus.ULPI_dir = 1'b1;
                state_nxt    = S_RD_DATA;
            end
            S_RD_DATA: begin
                bus.ULPI_dir    = 1'b1;
                bus.ULPI_data_t = 8'h00;
                bus.ULPI_data_o = rd_val;
                state_nxt       = S_RD_TA2;
            end
            S_RD_TA2: begin
                state_nxt = S_IDLE;
            end
            S_TX_PKT: begin
                bus.ULPI_nxt = 1'b1;
                if (bus.ULPI_stp) begin
                    pkt_done  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_RX_TA1: begin
                bus.ULPI_dir = 1'b1;
                state_nxt    = S_RX_DATA;
            end
            S_RX_DATA: begin
                bus.ULPI_dir    = 1'b1;
                bus.ULPI_data_t = 8'h00;
                bus.ULPI_data_o = rxd_q;
                state_nxt       = S_RX_TA2;
            end
            S_RX_TA2: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Command address, write data, RX CMD byte and packet length capture.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            addr_q  <= 6'd0;
            wdata_q <= 8'h00;
            rxd_q   <= 8'h00;
            len_q   <= 12'd0;
        end else begin
            if (tx_cmd) begin
                addr_q <= bus.ULPI_data_i[5:0];
            end
            if (tx_cmd && (bus.ULPI_data_i[7:6] == 2'b01)) begin
                len_q <= 12'd0;
            end
            if ((state == S_WR_DATA) && !bus.ULPI_stp) begin
                wdata_q <= bus.ULPI_data_i;
            end
            if (rx_accept) begin
                rxd_q <= bus.rxcmd_data;
            end
            if ((state == S_TX_PKT) && !bus.ULPI_stp && (len_q != 12'hFFF)) begin
                len_q <= len_q + 12'd1;
            end
        end
    end

    always_comb begin
        grp = 4'b0000;
        op  = OP_WR;
        case (addr_q)
            6'h04: begin grp = 4'b0001; op = OP_WR;  end
            6'h05: begin grp = 4'b0001; op = OP_SET; end
            6'h06: begin grp = 4'b0001; op = OP_CLR; end
            6'h07: begin grp = 4'b0010; op = OP_WR;  end
            6'h08: begin grp = 4'b0010; op = OP_SET; end
            6'h09: begin grp = 4'b0010; op = OP_CLR; end
            6'h0A: begin grp = 4'b0100; op = OP_WR;  end
            6'h0B: begin grp = 4'b0100; op = OP_SET; end
            6'h0C: begin grp = 4'b0100; op = OP_CLR; end
            6'h16: begin grp = 4'b1000; op = OP_WR;  end
            6'h17: begin grp = 4'b1000; op = OP_SET; end
            6'h18: begin grp = 4'b1000; op = OP_CLR; end
            default: begin
                grp = 4'b0000;
                op  = OP_WR;
            end
        endcase
    end

    always_comb begin
        rd_val = 8'h00;
        case (addr_q)
            6'h00:   rd_val = VENDOR_ID[7:0];
            6'h01:   rd_val = VENDOR_ID[15:8];
            6'h02:   rd_val = PRODUCT_ID[7:0];
            6'h03:   rd_val = PRODUCT_ID[15:8];
            default: rd_val = ({8{grp[0]}} & func_q)
                            | ({8{grp[1]}} & iface_q)
                            | ({8{grp[2]}} & otg_q)
                            | ({8{grp[3]}} & scratch_q);
        endcase
    end

    assign func_new = reg_update(op, func_q, wdata_q);

    // Function Control bit 5 is self-clearing: it never holds, it only fires the pulse.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            func_q    <= FUNC_RST;
            iface_q   <= IFACE_RST;
            otg_q     <= OTG_RST;
            scratch_q <= SCR_RST;
            pulse_q   <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            if (wr_commit) begin
                if (grp[0]) begin
                    func_q  <= func_new & 8'hDF;
                    pulse_q <= func_new[5];
                end
                if (grp[1]) begin
                    iface_q <= reg_update(op, iface_q, wdata_q);
                end
                if (grp[2]) begin
                    otg_q <= reg_update(op, otg_q, wdata_q);
                end
                if (grp[3]) begin
                    scratch_q <= reg_update(op, scratch_q, wdata_q);
                end
            end
        end
    end

    assign func_ctrl       = func_q;
    assign iface_ctrl      = iface_q;
    assign otg_ctrl        = otg_q;
    assign scratch         = scratch_q;
    assign phy_reset_pulse = pulse_q;
    assign pkt_len         = len_q;

endmodule

// File: tb/tb_ulpi_phy_regs.sv
// Bench for ulpi_phy_regs: transaction tasks build the per-cycle expected bus
// picture from the protocol timeline; a register map model tracks contents.
module tb_ulpi_phy_regs;

    localparam logic [15:0] VID = 16'h0424;
    localparam logic [15:0] PID = 16'h0009;

    logic        clk = 1'b0;
    logic        areset;
    logic        rst_v;
    logic [7:0]  func_ctrl, iface_ctrl, otg_ctrl, scratch;
    logic        phy_reset_pulse, pkt_done;
    logic [11:0] pkt_len;

    always #5 clk = ~clk;

    ulpi_phy_regs_if bus();

    ulpi_phy_regs #(.VENDOR_ID(VID), .PRODUCT_ID(PID)) dut (
        .aclk            (clk),
        .areset          (areset),
        .bus             (bus),
        .func_ctrl       (func_ctrl),
        .iface_ctrl      (iface_ctrl),
        .otg_ctrl        (otg_ctrl),
        .scratch         (scratch),
        .phy_reset_pulse (phy_reset_pulse),
        .pkt_done        (pkt_done),
        .pkt_len         (pkt_len)
    );

    typedef struct packed {
        logic        dir;
        logic        nxt;
        logic [7:0]  t;
        logic [7:0]  o;
        logic        rdy;
        logic        done;
        logic        pulse;
        logic        chk_len;
        logic [11:0] len;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    exp_t cur;
    logic exp_valid = 1'b0;
    logic pend_pulse;

    // register model: func, iface, otg, scratch; each has write/set/clear aliases
    logic [7:0] m_reg [4];
    int         base  [4] = '{4, 7, 10, 22};
    logic [5:0] addr_list [16] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                                   6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h16, 6'h17, 6'h2F};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_reg[0]   = 8'h41;
        m_reg[1]   = 8'h00;
        m_reg[2]   = 8'h06;
        m_reg[3]   = 8'h00;
        pend_pulse = 1'b0;
    endtask

    function automatic logic [7:0] model_read(input logic [5:0] a);
        int         ai;
        logic [15:0] id;
        ai = int'(a);
        if (ai < 4) begin
            id = (ai < 2) ? VID : PID;
            return ai[0] ? id[15:8] : id[7:0];
        end
        for (int g = 0; g < 4; g++)
            if (ai >= base[g] && ai < base[g] + 3) return m_reg[g];
        return 8'h00;
    endfunction

    task automatic model_commit(input logic [5:0] a, input logic [7:0] d);
        int         ai;
        int         opn;
        logic [7:0] v;
        ai = int'(a);
        for (int g = 0; g < 4; g++) begin
            if (ai >= base[g] && ai < base[g] + 3) begin
                opn = ai - base[g];
                v = (opn == 0) ? d : (opn == 1) ? (m_reg[g] | d) : (m_reg[g] & ~d);
                if (g == 0) begin
                    pend_pulse = v[5];
                    v[5]       = 1'b0;
                end
                m_reg[g] = v;
            end
        end
    endtask

    function automatic exp_t ex(input logic dir, input logic nxt, input logic [7:0] t,
                                input logic [7:0] o, input logic rdy);
        exp_t e;
        e     = '0;
        e.dir = dir;
        e.nxt = nxt;
        e.t   = t;
        e.o   = o;
        e.rdy = rdy;
        return e;
    endfunction

    function automatic exp_t ex_rst();
        exp_t e;
        e         = ex(1'b0, 1'b0, 8'hFF, 8'h00, 1'b0);
        e.chk_len = 1'b1;
        e.len     = 12'd0;
        return e;
    endfunction

    function automatic logic [7:0] rnd8();
        return 8'($urandom);
    endfunction

    always @(negedge clk) begin
        if (exp_valid) begin
            chk("dir",        32'(bus.ULPI_dir),    32'(cur.dir));
            chk("nxt",        32'(bus.ULPI_nxt),    32'(cur.nxt));
            chk("data_t",     32'(bus.ULPI_data_t), 32'(cur.t));
            chk("data_o",     32'(bus.ULPI_data_o), 32'(cur.o));
            chk("rxcmd_ready",32'(bus.rxcmd_ready), 32'(cur.rdy));
            chk("pkt_done",   32'(pkt_done),        32'(cur.done));
            chk("reset_pulse",32'(phy_reset_pulse), 32'(cur.pulse));
            chk("func_ctrl",  32'(func_ctrl),       32'(m_reg[0]));
            chk("iface_ctrl", 32'(iface_ctrl),      32'(m_reg[1]));
            chk("otg_ctrl",   32'(otg_ctrl),        32'(m_reg[2]));
            chk("scratch",    32'(scratch),         32'(m_reg[3]));
            if (cur.chk_len) chk("pkt_len", 32'(pkt_len), 32'(cur.len));
        end
    end

    // One bus cycle: drive inputs just after the edge, let the compare run at negedge.
    task automatic step(input logic [7:0] d, input logic s, input logic v,
                        input logic [7:0] rxd, input exp_t e);
        @(posedge clk);
        #1;
        areset          = rst_v;
        bus.ULPI_data_i = d;
        bus.ULPI_stp    = s;
        bus.rxcmd_valid = v;
        bus.rxcmd_data  = rxd;
        cur             = e;
        cur.pulse       = pend_pulse;
        pend_pulse      = 1'b0;
        exp_valid       = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 63));
            step(d, 1'($urandom), 1'b0, rnd8(), ex(1'b0, 1'b0, 8'hFF, 8'h00, d == 8'h00));
        end
    endtask

    // mode: 0 commit, 1 stp in N+1, 2 stp in N+2, 3 no stp at N+3
    task automatic reg_write(input logic [5:0] a, input logic [7:0] d, input int mode,
                             input logic rv_n);
        step({2'b10, a}, 1'b0, rv_n, rnd8(), ex(1'b0, 1'b0, 8'hFF, 8'h00, 1'b0));
        step(rnd8(), mode == 1, 1'b0, rnd8(), ex(1'b0, 1'b1, 8'hFF, 8'h00, 1'b0));
        if (mode == 1) return;
        step(d, mode == 2, 1'b0, rnd8(), ex(1'b0, 1'b1, 8'hFF, 8'h00, 1'b0));
        if (mode == 2) return;
        step(rnd8(), mode != 3, 1'b0, rnd8(), ex(1'b0, 1'b0, 8'hFF, 8'h00, 1'b0));
        if (mode != 3) model_commit(a, d);
    endtask

    task automatic reg_read(input logic [5:0] a, input logic [7:0] expv, input logic rv_n);
        step({2'b11, a}, 1'b0, rv_n, rnd8(), ex(1'b0, 1'b0, 8'hFF, 8'h00, 1'b0));
        step(rnd8(), 1'($urandom), 1'b0, rnd8(), ex(1'b0, 1'b1, 8'hFF, 8'h00, 1'b0));
        step(rnd8(), 1'($urandom), 1'b0, rnd8(), ex(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0));
        step(rnd8(), 1'($urandom), 1'b0, rnd8(), ex(1'b1, 1'b0, 8'h00, expv, 1'b0));
        step(rnd8(), 1'($urandom), 1'b0, rnd8(), ex(1'b0, 1'b0, 8'hFF, 8'h00, 1'b0));
    endtask

    task automatic packet(input int n);
        exp_t e;
        step({2'b01, 6'($urandom)}, 1'b0, 1'b0, rnd8(), ex(1'b0, 1'b0, 8'hFF, 8'h00, 1'b0));
        for (int i = 0; i < n; i++)
            step(rnd8(), 1'b0, 1'b0, rnd8(), ex(1'b0, 1'b1, 8'hFF, 8'h00, 1'b0));
        e         = ex(1'b0, 1'b1, 8'hFF, 8'h00, 1'b0);
        e.done    = 1'b1;
        e.chk_len = 1'b1;
        e.len     = (n > 4095) ? 12'hFFF : 12'(n);
        step(rnd8(), 1'b1, 1'b0, rnd8(), e);
    endtask

    task automatic rxcmd(input logic [7:0] d);
        step(8'h00, 1'($urandom), 1'b1, d, ex(1'b0, 1'b0, 8'hFF, 8'h00, 1'b1));
        step(rnd8(), 1'($urandom), 1'b0, rnd8(), ex(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0));
        step(rnd8(), 1'($urandom), 1'b0, rnd8(), ex(1'b1, 1'b0, 8'h00, d, 1'b0));
        step(rnd8(), 1'($urandom), 1'b0, rnd8(), ex(1'b0, 1'b0, 8'hFF, 8'h00, 1'b0));
    endtask

    function automatic logic [5:0] pick_addr();
        if ($urandom_range(0, 1) == 0) return addr_list[$urandom_range(0, 15)];
        return 6'($urandom);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not end, at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [5:0] a;
        bus.ULPI_data_i = 8'h00;
        bus.ULPI_stp    = 1'b0;
        bus.rxcmd_valid = 1'b0;
        bus.rxcmd_data  = 8'h00;
        areset          = 1'b1;
        rst_v           = 1'b1;
        model_reset();

        // reset holds the bus released and refuses RX CMDs
        repeat (2) step(8'h00, 1'b0, 1'b1, 8'h55, ex_rst());
        rst_v = 1'b0;

        reg_write(6'h16, 8'h5A, 0, 1'b0);
        reg_read(6'h16, 8'h5A, 1'b0);
        chk("scratch_lit", 32'(scratch), 32'h5A);

        reg_write(6'h0B, 8'h01, 0, 1'b0);
        reg_read(6'h0A, 8'h07, 1'b0);
        chk("otg_set_lit", 32'(otg_ctrl), 32'h07);
        reg_write(6'h0C, 8'h06, 0, 1'b0);
        reg_read(6'h0C, 8'h01, 1'b0);
        chk("otg_clr_lit", 32'(otg_ctrl), 32'h01);

        reg_write(6'h04, 8'h20, 0, 1'b0);
        idle(1);
        chk("pulse_lit", 32'(phy_reset_pulse), 32'h1);
        chk("func_lit", 32'(func_ctrl), 32'h00);
        idle(1);
        chk("pulse_gone_lit", 32'(phy_reset_pulse), 32'h0);
        reg_read(6'h00, 8'h24, 1'b0);
        reg_read(6'h01, 8'h04, 1'b0);
        reg_read(6'h02, 8'h09, 1'b0);
        reg_read(6'h03, 8'h00, 1'b0);

        reg_write(6'h16, 8'h77, 2, 1'b0);
        reg_write(6'h16, 8'h11, 1, 1'b0);
        reg_write(6'h16, 8'h22, 3, 1'b0);
        reg_read(6'h16, 8'h5A, 1'b0);
        reg_write(6'h00, 8'h55, 0, 1'b0);
        reg_read(6'h00, 8'h24, 1'b0);
        reg_write(6'h2F, 8'hAA, 0, 1'b0);
        reg_read(6'h2F, 8'h00, 1'b0);
        reg_read(6'h3E, 8'h00, 1'b0);

        packet(5);
        chk("pkt_len_lit", 32'(pkt_len), 32'd5);
        packet(0);
        packet(4100);
        chk("pkt_sat_lit", 32'(pkt_len), 32'hFFF);

        reg_read(6'h0A, 8'h01, 1'b1);
        rxcmd(8'h0C);

        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 4))
                0: begin
                    a = pick_addr();
                    reg_write(a, rnd8(), ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                              1'($urandom));
                end
                1: begin
                    a = pick_addr();
                    reg_read(a, model_read(a), 1'($urandom));
                end
                2: packet($urandom_range(0, 12));
                3: rxcmd(rnd8());
                default: idle($urandom_range(1, 3));
            endcase
        end

        // asynchronous reset while the PHY is driving read data (N+3)
        reg_write(6'h16, 8'hA5, 0, 1'b0);
        reg_write(6'h0A, 8'hF0, 0, 1'b0);
        step({2'b11, 6'h16}, 1'b0, 1'b0, 8'h00, ex(1'b0, 1'b0, 8'hFF, 8'h00, 1'b0));
        step(rnd8(), 1'b0, 1'b0, 8'h00, ex(1'b0, 1'b1, 8'hFF, 8'h00, 1'b0));
        step(rnd8(), 1'b0, 1'b0, 8'h00, ex(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0));
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        chk("pre_rst_dir", 32'(bus.ULPI_dir), 32'h1);
        chk("pre_rst_o", 32'(bus.ULPI_data_o), 32'hA5);
        #1;
        areset = 1'b1;
        rst_v  = 1'b1;
        #1;
        chk("rst_dir", 32'(bus.ULPI_dir), 32'h0);
        chk("rst_t", 32'(bus.ULPI_data_t), 32'hFF);
        chk("rst_o", 32'(bus.ULPI_data_o), 32'h00);
        chk("rst_func", 32'(func_ctrl), 32'h41);
        chk("rst_otg", 32'(otg_ctrl), 32'h06);
        chk("rst_scratch", 32'(scratch), 32'h00);
        model_reset();
        cur       = ex_rst();
        exp_valid = 1'b1;
        @(negedge clk);
        #1;
        step(8'h00, 1'b0, 1'b1, rnd8(), ex_rst());
        rst_v = 1'b0;
        reg_write(6'h17, 8'h3C, 0, 1'b0);
        reg_read(6'h16, 8'h3C, 1'b0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
